hazard_scoreboard: RTL and testbench

Parametrised hazard unit for the multi-issue ID stage; generalises single-lane load-use/control hazard detection to a register scoreboard. Tracks every register with an outstanding long-latency write (load, AES coprocessor result), decides per lane whether the ID bundle may issue, and generates a multi-cycle flush window on control redirects. Sits between the ID decoders and the ID/EX register; completions arrive from WB.

---
 rtl/hazard_scoreboard.sv | 157 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Multi-issue ID-stage hazard unit: register scoreboard for long-latency writes,
// per-lane issue decision (thermometer across lanes) and a redirect flush window.

module hazard_lane #(
    parameter int IDX_W    = 5,
    parameter int NREG     = 32,
    parameter int CW       = 3,
    parameter int MAX_PEND = 4
) (
    input  logic             i_valid,
    input  logic             i_long,
    input  logic [IDX_W-1:0] i_rs,
    input  logic [IDX_W-1:0] i_rt,
    input  logic [NREG-1:0]  i_busy,
    input  logic [NREG-1:0]  i_older_wr,
    input  logic [CW-1:0]    i_pend_older,
    output logic             o_ok
);
    logic w_src_blk;
    logic w_cap_ok;

    // i_busy already has WB forwarding applied and reg 0 cleared
    assign w_src_blk = i_busy[i_rs] | i_busy[i_rt] | i_older_wr[i_rs] | i_older_wr[i_rt];
    assign w_cap_ok  = ~i_long | (i_pend_older < CW'(MAX_PEND));
    assign o_ok      = i_valid & ~w_src_blk & w_cap_ok;
endmodule

module hazard_scoreboard #(
    parameter int LANES     = 2,
    parameter int IDX_W     = 5,
    parameter int MAX_PEND  = 4,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LANES-1:0]              in_valid,
    input  logic [LANES*IDX_W-1:0]        in_rs_idx,
    input  logic [LANES*IDX_W-1:0]        in_rt_idx,
    input  logic [LANES*IDX_W-1:0]        in_rd_idx,
    input  logic [LANES-1:0]              in_rd_we,
    input  logic [LANES-1:0]              in_long_op,
    input  logic                          in_wb_valid,
    input  logic [IDX_W-1:0]              in_wb_idx,
    input  logic [1:0]                    in_IDEX_PCSrc,
    output logic [LANES-1:0]              out_issue,
    output logic                          out_data_hazard,
    output logic                          out_flush,
    output logic [$clog2(MAX_PEND+1)-1:0] out_pend_cnt,
    output logic [CNT_W-1:0]              out_stall_cnt
);
    localparam int NREG = 1 << IDX_W;
    localparam int PC_W = $clog2(MAX_PEND+1);
    localparam int CW   = $clog2(MAX_PEND+LANES+1);
    localparam logic [2:0] FL_LOAD = 3'(FLUSH_CYC);

    logic [NREG-1:0]  r_busy;
    logic [PC_W-1:0]  r_pend;
    logic [2:0]       r_flush_cnt;
    logic [CNT_W-1:0] r_stall;

    logic [NREG-1:0]            w_busy_eff;
    logic [LANES:0][NREG-1:0]   w_older_wr;
    logic [LANES:0][CW-1:0]     w_older_long;
    logic [LANES-1:0]           w_lane_ok;
    logic [LANES-1:0]           w_issue;
    logic                       w_hazard;
    logic                       w_flush;
    logic [IDX_W-1:0]           w_rd;
    logic [IDX_W-1:0]           w_rd2;
    logic                       w_chain;
    logic [NREG-1:0]            w_set;
    logic [NREG-1:0]            w_clr_mask;
    logic [CW-1:0]              w_nset;
    logic                       w_clr;
    logic [CW-1:0]              w_pend_nxt;

    assign w_flush = (r_flush_cnt != 3'd0);

    // Older-lane write set and long-op occupancy seen by each lane
    always_comb begin
        w_busy_eff = r_busy;
        if (in_wb_valid) w_busy_eff[in_wb_idx] = 1'b0;
        w_busy_eff[0] = 1'b0;
        w_rd = '0;
        w_older_wr[0]   = '0;
        w_older_long[0] = CW'(r_pend);
        for (int i = 0; i < LANES; i++) begin
            w_rd = in_rd_idx[i*IDX_W +: IDX_W];
            w_older_wr[i+1]   = w_older_wr[i];
            w_older_long[i+1] = w_older_long[i] + CW'(in_valid[i] & in_long_op[i]);
            if (in_valid[i] && in_rd_we[i] && w_rd != '0) w_older_wr[i+1][w_rd] = 1'b1;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        hazard_lane #(.IDX_W(IDX_W), .NREG(NREG), .CW(CW), .MAX_PEND(MAX_PEND)) u_lane (
            .i_valid      (in_valid[g]),
            .i_long       (in_long_op[g]),
            .i_rs         (in_rs_idx[g*IDX_W +: IDX_W]),
            .i_rt         (in_rt_idx[g*IDX_W +: IDX_W]),
            .i_busy       (w_busy_eff),
            .i_older_wr   (w_older_wr[g]),
            .i_pend_older (w_older_long[g]),
            .o_ok         (w_lane_ok[g])
        );
    end

    always_comb begin
        w_issue = '0;
        w_chain = ~rst & ~w_flush;
        for (int i = 0; i < LANES; i++) begin
            w_chain    = w_chain & w_lane_ok[i];
            w_issue[i] = w_chain;
        end
        w_hazard = ~rst & ((in_valid[0] & ~w_issue[0]) | (w_issue[0] & |(in_valid & ~w_issue)));
    end

    // Scoreboard update: clear first, then set, so a same-cycle set wins
    always_comb begin
        w_set  = '0;
        w_nset = '0;
        w_rd2  = '0;
        for (int i = 0; i < LANES; i++) begin
            w_rd2 = in_rd_idx[i*IDX_W +: IDX_W];
            if (w_issue[i] && in_long_op[i] && in_rd_we[i] && w_rd2 != '0) begin
                w_set[w_rd2] = 1'b1;
                w_nset       = w_nset + CW'(1);
            end
        end
        w_clr      = in_wb_valid & r_busy[in_wb_idx];
        w_clr_mask = '0;
        if (w_clr) w_clr_mask[in_wb_idx] = 1'b1;
        w_pend_nxt = CW'(r_pend) + w_nset - CW'(w_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= '0;
            r_pend      <= '0;
            r_flush_cnt <= '0;
            r_stall     <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_clr_mask) | w_set) & ~NREG'(1);
            r_pend <= PC_W'(w_pend_nxt);
            if (in_IDEX_PCSrc != 2'b00) r_flush_cnt <= FL_LOAD;
            else if (w_flush)           r_flush_cnt <= r_flush_cnt - 3'd1;
            if (w_hazard && r_stall != '1) r_stall <= r_stall + CNT_W'(1);
        end
    end

    assign out_issue       = w_issue;
    assign out_data_hazard = w_hazard;
    assign out_flush       = w_flush;
    assign out_pend_cnt    = r_pend;
    assign out_stall_cnt   = r_stall;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: driver pushes reference-model expectations, monitor compares each cycle.
module tb_hazard_scoreboard;
    localparam int LANES = 2, IDX_W = 5, MAX_PEND = 4, FLUSH_CYC = 3, CNT_W = 6;

    typedef struct packed {
        logic       rst;
        logic [1:0] valid;
        logic [9:0] rs, rt, rd;
        logic [1:0] we, lng;
        logic       wbv;
        logic [4:0] wbi;
        logic [1:0] pc;
    } stim_t;

    typedef struct packed {
        logic [1:0] issue;
        logic       haz;
        logic       flush;
        logic [2:0] pend;
        logic [5:0] stall;
    } exp_t;

    logic clk = 0, rst = 1;
    logic [1:0] in_valid = 0, in_rd_we = 0, in_long_op = 0, in_pc = 0;
    logic [9:0] in_rs = 0, in_rt = 0, in_rd = 0;
    logic in_wbv = 0;
    logic [4:0] in_wbi = 0;
    logic [1:0] out_issue;
    logic out_haz, out_flush;
    logic [2:0] out_pend;
    logic [5:0] out_stall;

    hazard_scoreboard #(.LANES(LANES), .IDX_W(IDX_W), .MAX_PEND(MAX_PEND),
                        .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_rs_idx(in_rs), .in_rt_idx(in_rt),
        .in_rd_idx(in_rd), .in_rd_we(in_rd_we), .in_long_op(in_long_op),
        .in_wb_valid(in_wbv), .in_wb_idx(in_wbi), .in_IDEX_PCSrc(in_pc),
        .out_issue(out_issue), .out_data_hazard(out_haz), .out_flush(out_flush),
        .out_pend_cnt(out_pend), .out_stall_cnt(out_stall));

    always #5 clk = ~clk;

    exp_t q[$];
    int passed = 0, total = 0;

    // Reference model: register file of busy flags plus plain counters
    bit m_busy[32];
    int m_pend = 0, m_frem = 0, m_stall = 0;

    function automatic bit src_busy(stim_t s, int idx);
        return idx != 0 && m_busy[idx] && !(s.wbv && s.wbi == idx);
    endfunction

    task automatic model(input stim_t s, output exp_t e);
        bit go, ok, haz;
        bit wr[32];
        int older_long, rs, rt, rd;
        logic [1:0] iss;
        iss = 0; haz = 0;
        e.flush = (m_frem != 0);
        e.pend  = 3'(m_pend);
        e.stall = 6'(m_stall);
        if (!s.rst) begin
            go = (m_frem == 0);
            older_long = 0;
            foreach (wr[k]) wr[k] = 0;
            for (int i = 0; i < LANES; i++) begin
                rs = int'(s.rs[i*5 +: 5]); rt = int'(s.rt[i*5 +: 5]); rd = int'(s.rd[i*5 +: 5]);
                ok = go && s.valid[i] && !src_busy(s, rs) && !src_busy(s, rt) && !wr[rs] && !wr[rt];
                if (s.lng[i] && m_pend + older_long >= MAX_PEND) ok = 0;
                if (ok) iss[i] = 1; else go = 0;
                if (s.valid[i] && s.we[i] && rd != 0) wr[rd] = 1;
                if (s.valid[i] && s.lng[i]) older_long++;
            end
            haz = (s.valid[0] && !iss[0]) || (iss[0] && (s.valid & ~iss) != 0);
        end
        e.issue = iss;
        e.haz   = haz;
        if (s.rst) begin
            foreach (m_busy[k]) m_busy[k] = 0;
            m_pend = 0; m_frem = 0; m_stall = 0;
        end else begin
            if (s.wbv && m_busy[s.wbi]) begin m_busy[s.wbi] = 0; m_pend--; end
            for (int i = 0; i < LANES; i++) begin
                rd = int'(s.rd[i*5 +: 5]);
                if (iss[i] && s.lng[i] && s.we[i] && rd != 0) begin m_busy[rd] = 1; m_pend++; end
            end
            if (s.pc != 0) m_frem = FLUSH_CYC;
            else if (m_frem > 0) m_frem--;
            if (haz && m_stall < (1 << CNT_W) - 1) m_stall++;
        end
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        @(posedge clk); #1;
        rst = s.rst; in_valid = s.valid; in_rs = s.rs; in_rt = s.rt; in_rd = s.rd;
        in_rd_we = s.we; in_long_op = s.lng; in_wbv = s.wbv; in_wbi = s.wbi; in_pc = s.pc;
        model(s, e);
        q.push_back(e);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // lane l: op with rs, rt, rd; long op implies a register write
    function automatic stim_t lane(input stim_t s0, int l, int rs, int rt, int rd, bit lng);
        stim_t s;
        s = s0;
        s.valid[l] = 1; s.rs[l*5 +: 5] = 5'(rs); s.rt[l*5 +: 5] = 5'(rt);
        s.rd[l*5 +: 5] = 5'(rd); s.we[l] = 1; s.lng[l] = lng;
        return s;
    endfunction

    function automatic stim_t wb(input stim_t s0, int idx);
        stim_t s;
        s = s0; s.wbv = 1; s.wbi = 5'(idx);
        return s;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            total += 5;
            if (out_issue !== e.issue) $display("FAIL issue: got %b want %b @%0t", out_issue, e.issue, $time);
            else passed++;
            if (out_haz !== e.haz) $display("FAIL data_hazard: got %b want %b @%0t", out_haz, e.haz, $time);
            else passed++;
            if (out_flush !== e.flush) $display("FAIL flush: got %b want %b @%0t", out_flush, e.flush, $time);
            else passed++;
            if (out_pend !== e.pend) $display("FAIL pend_cnt: got %0d want %0d @%0t", out_pend, e.pend, $time);
            else passed++;
            if (out_stall !== e.stall) $display("FAIL stall_cnt: got %0d want %0d @%0t", out_stall, e.stall, $time);
            else passed++;
        end
    end

    initial begin
        stim_t s, r;
        r = idle(); r.rst = 1;
        step(r); step(r);
        // load-use with WB forwarding
        step(lane(idle(), 0, 1, 2, 8, 1));
        repeat (2) step(lane(idle(), 0, 8, 1, 9, 0));
        step(wb(lane(idle(), 0, 8, 1, 9, 0), 8));
        // intra-bundle RAW split
        step(lane(lane(idle(), 0, 1, 2, 3, 0), 1, 3, 5, 4, 0));
        step(lane(idle(), 0, 3, 5, 4, 0));
        // fill to MAX_PEND, then a blocked fifth long op
        step(lane(lane(idle(), 0, 1, 1, 10, 1), 1, 1, 1, 11, 1));
        step(lane(lane(idle(), 0, 1, 1, 12, 1), 1, 1, 1, 13, 1));
        step(lane(idle(), 0, 1, 1, 14, 1));
        step(wb(lane(idle(), 0, 1, 1, 14, 1), 10));
        step(lane(idle(), 0, 1, 1, 14, 1));
        step(idle());
        // redirect window and re-trigger mid-window
        s = lane(idle(), 0, 1, 2, 3, 0); s.pc = 2'b01;
        step(s);
        step(lane(idle(), 0, 1, 2, 3, 0));
        s = lane(idle(), 0, 1, 2, 3, 0); s.pc = 2'b10;
        step(s);
        repeat (4) step(lane(idle(), 0, 1, 2, 3, 0));
        // drain, then same-cycle set/clear and WB to an idle register
        step(wb(idle(), 11)); step(wb(idle(), 12)); step(wb(idle(), 13)); step(wb(idle(), 14));
        step(lane(idle(), 0, 1, 1, 8, 1));
        step(wb(lane(idle(), 0, 1, 1, 8, 1), 8));
        step(wb(idle(), 20));
        step(wb(idle(), 0));
        // two lanes to the same rd, then reset with ops pending
        step(lane(lane(idle(), 0, 1, 1, 7, 1), 1, 2, 2, 7, 1));
        step(lane(idle(), 0, 7, 1, 2, 0));
        step(r);
        step(lane(idle(), 0, 7, 1, 2, 0));
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            s = idle();
            s.rst   = ($urandom_range(0, 199) == 0);
            s.valid = 2'($urandom);
            s.rs    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            s.rt    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            s.rd    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            s.we    = 2'($urandom);
            s.lng   = 2'($urandom) & 2'($urandom);
            s.wbv   = ($urandom_range(0, 9) < 4);
            s.wbi   = 5'($urandom_range(0, 7));
            s.pc    = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(s);
        end
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) $display("FAIL drain: got %0d left want 0", q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
